regfile_write_decoder: RTL and testbench
========================================

// Module: regfile_write_decoder
// PURPOSE
//   Parametrised, registered write-select decoder for the register file: turns a
//   binary write address into a one-hot write strobe, one cycle after acceptance.
//   Adds a valid/ready write handshake and a hardware clear sequencer that walks
//   every register in turn. Sits between the write-back stage and the register array.
// PARAMETERS
//   ADDR_W     3   address width; NUM_OUT = 2**ADDR_W select lines (localparam)
//   SKIP_ZERO  0   1: register 0 is hardwired; address 0 never raises a strobe
// PORTS
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous reset, active low
//   wr_valid   in   1        write request
//   wr_addr    in   ADDR_W   write address, sampled when wr_valid & wr_ready
//   wr_ready   out  1        decoder can accept a write this cycle
//   clr_start  in   1        single-cycle request to clear all registers
//   clr_busy   out  1        clear sequence in progress
//   clr_done   out  1        one-cycle pulse on the final clear strobe
//   sel_o      out  NUM_OUT  registered one-hot write strobe (all-zero = no write)
//   clr_active out  1        registered; 1 when sel_o is a clear strobe (write zero)
//   wr_par     in   1        [REGFILE_DEC_PARITY_EN only] even parity of wr_addr
//   err_par    out  1        [REGFILE_DEC_PARITY_EN only] parity-error pulse
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, counter 0, sel_o=0, clr_active=0,
//     clr_busy=0, clr_done=0, err_par=0. Takes effect mid-clear; sequence abandoned.
//   FSM states: IDLE, CLEAR.
//   wr_ready = (state==IDLE) & ~clr_start (combinational). Write accepted on
//     wr_valid & wr_ready; cycle N+1: sel_o = 1<<wr_addr, clr_active=0. Latency 1.
//   Back-to-back writes accepted every cycle; sel_o=0 in any cycle after no accept.
//   SKIP_ZERO=1 and wr_addr==0: write accepted (handshake completes), sel_o=0.
//   IDLE & clr_start -> CLEAR; clr_start wins over a same-cycle wr_valid (write
//     not accepted, requester must hold wr_valid). Counter loads start index
//     S = SKIP_ZERO ? 1 : 0.
//   CLEAR: each cycle sel_o(next) = 1<<count, clr_active(next)=1, count++.
//     clr_busy=1 (registered, asserted from the cycle after clr_start until the
//     cycle after the last strobe). Strobes occupy NUM_OUT-S consecutive cycles,
//     indices S..NUM_OUT-1 ascending.
//   Last index (count==NUM_OUT-1): clr_done pulses together with the last
//     strobe; state -> IDLE; counter not wrapped into another pass.
//   clr_start during CLEAR is ignored (no restart, no extension).
//   sel_o is always one-hot or zero; never two bits set.
// CONFIGURATION
//   REGFILE_DEC_PARITY_EN defined: wr_par/err_par ports exist. On an accepted write
//     with ^{wr_addr,wr_par}==1 the write is dropped (sel_o=0 next cycle) and
//     err_par pulses high for one cycle aligned with that sel_o. Clear unaffected.
//   Not defined: ports absent, no check, every accepted write decodes.
// TESTING
//   1 rst_n low mid-CLEAR at index 3 -> same cycle sel_o=0, clr_busy=0; after
//     release wr_ready=1, next clear starts from S.
//   2 ADDR_W=3: accepted writes 5,0,7 back-to-back -> sel_o 8'h20,8'h01,8'h80 on
//     the next 3 cycles, clr_active=0.
//   3 clr_start with SKIP_ZERO=0 -> sel_o 8'h01..8'h80 over 8 cycles, clr_done with
//     8'h80, wr_ready=0 throughout; SKIP_ZERO=1 -> 8'h02..8'h80, 7 cycles.
//   4 clr_start and wr_valid (addr 4) same cycle -> no 8'h10 write strobe;
//     held wr_valid accepted first cycle after return to IDLE.
//   5 SKIP_ZERO=1, write addr 0 -> wr_ready=1, sel_o stays 0; ADDR_W=5 addr 31 ->
//     sel_o bit 31 only.
//   6 REGFILE_DEC_PARITY_EN: addr 3'b011, wr_par=1 -> sel_o=0, err_par=1 one
//     cycle; wr_par=0 -> sel_o=8'h08, err_par=0.

Source files
------------

// File: rtl/regfile_write_decoder.sv
// regfile_write_decoder: registered one-hot write-strobe decoder for the
// register file. It has a valid/ready write port and a clear sequencer that
// strobes every register in ascending order with clr_active set, so the
// array writes zero.
// Optional feature: define REGFILE_DEC_PARITY_EN to add the wr_par input and
// the err_par output. With that macro defined, a write whose address parity
// is bad is dropped and err_par is flagged.
module regfile_write_decoder #(
  parameter int ADDR_W    = 3,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [ADDR_W-1:0]        wr_addr,
  output logic                     wr_ready,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic [(1<<ADDR_W)-1:0]   sel_o,
  output logic                     clr_active
`ifdef REGFILE_DEC_PARITY_EN
  ,
  input  logic                     wr_par,
  output logic                     err_par
`endif
);

  localparam int NUM_OUT = 1 << ADDR_W;
  // Register 0 is skipped by the clear walk when it is hardwired.
  localparam logic [ADDR_W-1:0] START = SKIP_ZERO ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    count_q, count_d;
  logic [NUM_OUT-1:0]   sel_q, sel_d;
  logic                 clr_active_q, clr_active_d;
  logic                 clr_busy_q, clr_busy_d;
  logic                 clr_done_q, clr_done_d;
  logic                 wr_accept;
  logic                 par_bad;
`ifdef REGFILE_DEC_PARITY_EN
  logic                 err_par_q, err_par_d;
`endif

  // A pending clear request takes priority over a write in the same cycle.
  assign wr_ready  = (state_q == IDLE) && !clr_start;
  assign wr_accept = wr_valid && wr_ready;

`ifdef REGFILE_DEC_PARITY_EN
  assign par_bad = ^{wr_addr, wr_par};
`else
  assign par_bad = 1'b0;
`endif

  // Next-state and next-output logic for both the write decode and the clear walk.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    sel_d        = '0;
    clr_active_d = 1'b0;
    clr_busy_d   = 1'b0;
    clr_done_d   = 1'b0;
`ifdef REGFILE_DEC_PARITY_EN
    err_par_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d    = CLEAR;
          count_d    = START;
          clr_busy_d = 1'b1;
        end else if (wr_accept) begin
          if (par_bad) begin
`ifdef REGFILE_DEC_PARITY_EN
            err_par_d = 1'b1;
`endif
          end else if (!(SKIP_ZERO && (wr_addr == '0))) begin
            sel_d[wr_addr] = 1'b1;
          end
        end
      end
      CLEAR: begin
        // clr_start is not examined here, so a repeat request cannot restart the walk.
        sel_d[count_q] = 1'b1;
        clr_active_d   = 1'b1;
        // Busy stays high through the cycle that shows the final strobe.
        clr_busy_d     = 1'b1;
        if (count_q == LAST) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end else begin
          count_d = count_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; the async reset abandons any clear in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      sel_q        <= '0;
      clr_active_q <= 1'b0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
`ifdef REGFILE_DEC_PARITY_EN
      err_par_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      sel_q        <= sel_d;
      clr_active_q <= clr_active_d;
      clr_busy_q   <= clr_busy_d;
      clr_done_q   <= clr_done_d;
`ifdef REGFILE_DEC_PARITY_EN
      err_par_q    <= err_par_d;
`endif
    end
  end

  assign sel_o      = sel_q;
  assign clr_active = clr_active_q;
  assign clr_busy   = clr_busy_q;
  assign clr_done   = clr_done_q;
`ifdef REGFILE_DEC_PARITY_EN
  assign err_par    = err_par_q;
`endif

endmodule

// File: tb/tb_regfile_write_decoder.sv
// Directed bench for regfile_write_decoder with three instances:
// ADDR_W=3 with SKIP_ZERO=0, ADDR_W=3 with SKIP_ZERO=1, and ADDR_W=5 with
// SKIP_ZERO=1. Each step pushes its expected outputs to a scoreboard queue,
// and the queue is popped one clock later.
module tb_regfile_write_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic cs0 = 1'b0, cs1 = 1'b0, cs2 = 1'b0;
  logic [2:0] a0 = '0, a1 = '0;
  logic [4:0] a2 = '0;
  logic r0, r1, r2, b0, b1, b2, d0, d1, d2, act0, act1, act2;
  logic [7:0]  s0, s1;
  logic [31:0] s2;
`ifdef REGFILE_DEC_PARITY_EN
  logic p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;
  logic e0, e1, e2;
`endif

  regfile_write_decoder #(.ADDR_W(3), .SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_valid(v0), .wr_addr(a0), .wr_ready(r0),
    .clr_start(cs0), .clr_busy(b0), .clr_done(d0), .sel_o(s0), .clr_active(act0)
`ifdef REGFILE_DEC_PARITY_EN
    , .wr_par(p0), .err_par(e0)
`endif
  );
  regfile_write_decoder #(.ADDR_W(3), .SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(v1), .wr_addr(a1), .wr_ready(r1),
    .clr_start(cs1), .clr_busy(b1), .clr_done(d1), .sel_o(s1), .clr_active(act1)
`ifdef REGFILE_DEC_PARITY_EN
    , .wr_par(p1), .err_par(e1)
`endif
  );
  regfile_write_decoder #(.ADDR_W(5), .SKIP_ZERO(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_valid(v2), .wr_addr(a2), .wr_ready(r2),
    .clr_start(cs2), .clr_busy(b2), .clr_done(d2), .sel_o(s2), .clr_active(act2)
`ifdef REGFILE_DEC_PARITY_EN
    , .wr_par(p2), .err_par(e2)
`endif
  );

  typedef struct {
    logic [31:0] sel;
    logic        act;
    logic        done;
    logic        busy;
    logic        perr;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic get_out(input int d, output logic [31:0] sel, output logic act,
                         output logic done, output logic busy, output logic rdy,
                         output logic perr);
    perr = 1'b0;
    case (d)
      0: begin
        sel = {24'h0, s0}; act = act0; done = d0; busy = b0; rdy = r0;
`ifdef REGFILE_DEC_PARITY_EN
        perr = e0;
`endif
      end
      1: begin
        sel = {24'h0, s1}; act = act1; done = d1; busy = b1; rdy = r1;
`ifdef REGFILE_DEC_PARITY_EN
        perr = e1;
`endif
      end
      default: begin
        sel = s2; act = act2; done = d2; busy = b2; rdy = r2;
`ifdef REGFILE_DEC_PARITY_EN
        perr = e2;
`endif
      end
    endcase
  endtask

  // Drives one cycle of stimulus on instance d, checks wr_ready before the
  // edge, queues the expected outputs, then pops and compares them after the edge.
  task automatic step(input int d, input logic v, input logic [4:0] a, input logic cs,
                      input logic badp, input logic exp_rdy, input logic [31:0] esel,
                      input logic eact, input logic edone, input logic ebusy,
                      input logic eperr, input string tag);
    exp_t e;
    logic [31:0] sel;
    logic act, done, busy, rdy, perr;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
    case (d)
      0: begin v0 = v; a0 = a[2:0]; cs0 = cs; end
      1: begin v1 = v; a1 = a[2:0]; cs1 = cs; end
      default: begin v2 = v; a2 = a; cs2 = cs; end
    endcase
`ifdef REGFILE_DEC_PARITY_EN
    p0 = ^a0 ^ (badp && d == 0);
    p1 = ^a1 ^ (badp && d == 1);
    p2 = ^a2 ^ (badp && d == 2);
`else
    if (badp) $display("note: %s parity injection has no effect in this build", tag);
`endif
    #1;
    get_out(d, sel, act, done, busy, rdy, perr);
    chk({tag, "/wr_ready"}, {31'h0, rdy}, {31'h0, exp_rdy});
    e.sel = esel; e.act = eact; e.done = edone; e.busy = ebusy; e.perr = eperr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    get_out(d, sel, act, done, busy, rdy, perr);
    chk({tag, "/sel_o"}, sel, e.sel);
    chk({tag, "/clr_active"}, {31'h0, act}, {31'h0, e.act});
    chk({tag, "/clr_done"}, {31'h0, done}, {31'h0, e.done});
    chk({tag, "/clr_busy"}, {31'h0, busy}, {31'h0, e.busy});
`ifdef REGFILE_DEC_PARITY_EN
    chk({tag, "/err_par"}, {31'h0, perr}, {31'h0, e.perr});
`endif
    $display("step %-12s dut%0d v=%0d a=%0d cs=%0d -> sel=%0h act=%0d done=%0d busy=%0d",
             tag, d, v, a, cs, sel, act, done, busy);
  endtask

  // Idle step helper: nothing requested on instance d.
  task automatic idle(input int d, input logic [31:0] esel, input logic eact,
                      input logic edone, input logic ebusy, input logic exp_rdy,
                      input string tag);
    step(d, 1'b0, 5'd0, 1'b0, 1'b0, exp_rdy, esel, eact, edone, ebusy, 1'b0, tag);
  endtask

  initial begin
    logic [31:0] sel;
    logic act, done, busy, rdy, perr;

    // Reset values on all three instances.
    #1 rst_n = 1'b0;
    #11;
    for (int d = 0; d < 3; d++) begin
      get_out(d, sel, act, done, busy, rdy, perr);
      chk($sformatf("rst%0d/sel_o", d), sel, 32'h0);
      chk($sformatf("rst%0d/clr_busy", d), {31'h0, busy}, 32'h0);
      chk($sformatf("rst%0d/clr_done", d), {31'h0, done}, 32'h0);
      chk($sformatf("rst%0d/clr_active", d), {31'h0, act}, 32'h0);
`ifdef REGFILE_DEC_PARITY_EN
      chk($sformatf("rst%0d/err_par", d), {31'h0, perr}, 32'h0);
`endif
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back writes 5, 0, 7, then an idle cycle.
    step(0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, "wr5");
    step(0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 32'h01, 1'b0, 1'b0, 1'b0, 1'b0, "wr0");
    step(0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, "wr7");
    idle(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "wr_idle");

    // Full clear with SKIP_ZERO=0: strobes 0x01..0x80.
    step(0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "clr0_go");
    for (int i = 0; i < 8; i++)
      idle(0, 32'h1 << i, 1'b1, (i == 7), 1'b1, 1'b0, $sformatf("clr0_s%0d", i));
    idle(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "clr0_end");

    // Clear with SKIP_ZERO=1: strobes 0x02..0x80; a repeated clr_start is ignored.
    step(1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "clr1_go");
    for (int i = 1; i < 8; i++)
      step(1, 1'b0, 5'd0, (i == 3), 1'b0, 1'b0, 32'h1 << i, 1'b1, (i == 7), 1'b1, 1'b0,
           $sformatf("clr1_s%0d", i));
    idle(1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "clr1_end");

    // clr_start wins over a write to 4; the held write lands after the clear.
    step(0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "race_go");
    for (int i = 0; i < 8; i++)
      step(0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h1 << i, 1'b1, (i == 7), 1'b1, 1'b0,
           $sformatf("race_s%0d", i));
    step(0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, "race_wr");
    idle(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "race_idle");

    // Hardwired register 0, and the wide address variant.
    step(1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "skip_wr0");
    step(1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 32'h02, 1'b0, 1'b0, 1'b0, 1'b0, "skip_wr1");
    step(2, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, "w5_wr31");
    step(2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "w5_wr0");
    step(2, 1'b1, 5'd17, 1'b0, 1'b0, 1'b1, 32'h0002_0000, 1'b0, 1'b0, 1'b0, 1'b0, "w5_wr17");
    step(2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "clr5_go");
    for (int i = 1; i < 32; i++)
      idle(2, 32'h1 << i, 1'b1, (i == 31), 1'b1, 1'b0, $sformatf("clr5_s%0d", i));
    idle(2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "clr5_end");

`ifdef REGFILE_DEC_PARITY_EN
    // Bad parity drops the write and flags err_par; good parity decodes normally.
    step(0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "par_bad");
    step(0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 32'h08, 1'b0, 1'b0, 1'b0, 1'b0, "par_good");
    idle(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "par_idle");
`endif

    // Async reset in the middle of a clear, showing index 3.
    step(0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "mid_go");
    for (int i = 0; i < 4; i++)
      idle(0, 32'h1 << i, 1'b1, 1'b0, 1'b1, 1'b0, $sformatf("mid_s%0d", i));
    #2 rst_n = 1'b0;
    #1;
    get_out(0, sel, act, done, busy, rdy, perr);
    chk("midrst/sel_o", sel, 32'h0);
    chk("midrst/clr_busy", {31'h0, busy}, 32'h0);
    chk("midrst/clr_active", {31'h0, act}, 32'h0);
    chk("midrst/clr_done", {31'h0, done}, 32'h0);
    $display("step midrst       dut0 rst_n=0 -> sel=%0h busy=%0d", sel, busy);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst");
    step(0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "rclr_go");
    for (int i = 0; i < 8; i++)
      idle(0, 32'h1 << i, 1'b1, (i == 7), 1'b1, 1'b0, $sformatf("rclr_s%0d", i));
    idle(0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "rclr_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
